univ_register: RTL



---
 rtl/univ_register_pkg.sv | 21 ++
 rtl/univ_register_next.sv | 86 ++++++++
 rtl/univ_register.sv | 89 ++++++++
 3 files changed

// File: rtl/univ_register_pkg.sv
`default_nettype none
// ============================================================================
// Module   : univ_register_pkg
// Purpose  : Shared operation encodings for the universal datapath register.
// Revision : 1.0 - initial release
// ============================================================================
package univ_register_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_INC  = 3'b101;
  localparam logic [MODE_W-1:0] MODE_DEC  = 3'b110;
  localparam logic [MODE_W-1:0] MODE_ASR  = 3'b111;

endpackage : univ_register_pkg
`default_nettype wire

// File: rtl/univ_register_next.sv
`default_nettype none
// ============================================================================
// Module   : univ_register_next
// Purpose  : Combinational next-state logic for univ_register: selects the
//            new q / sout / carry from load, en and the operation mode.
// Revision : 1.0 - initial release
// ============================================================================
module univ_register_next
  import univ_register_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]  q,
  input  logic              sout,
  input  logic              carry,
  input  logic              load,
  input  logic [WIDTH-1:0]  d,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic              sin,
  output logic [WIDTH-1:0]  q_next,
  output logic              sout_next,
  output logic              carry_next
);

  localparam logic [WIDTH:0] C_ONE = {{WIDTH{1'b0}}, 1'b1};

  // One extra bit on the arithmetic results carries the carry/borrow out.
  logic [WIDTH:0] w_inc;
  logic [WIDTH:0] w_dec;

  assign w_inc = {1'b0, q} + C_ONE;
  assign w_dec = {1'b0, q} - C_ONE;

  // Priority load > en; each mode only touches the flag it defines.
  always_comb begin
    q_next     = q;
    sout_next  = sout;
    carry_next = carry;
    if (load) begin
      q_next     = d;
      sout_next  = 1'b0;
      carry_next = 1'b0;
    end else if (en) begin
      case (mode)
        MODE_HOLD: begin
          q_next = q;
        end
        MODE_SHL: begin
          q_next    = {q[WIDTH-2:0], sin};
          sout_next = q[WIDTH-1];
        end
        MODE_SHR: begin
          q_next    = {sin, q[WIDTH-1:1]};
          sout_next = q[0];
        end
        MODE_ROL: begin
          q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
          sout_next = q[WIDTH-1];
        end
        MODE_ROR: begin
          q_next    = {q[0], q[WIDTH-1:1]};
          sout_next = q[0];
        end
        MODE_INC: begin
          q_next     = w_inc[WIDTH-1:0];
          carry_next = w_inc[WIDTH];
        end
        MODE_DEC: begin
          q_next     = w_dec[WIDTH-1:0];
          carry_next = w_dec[WIDTH];
        end
        MODE_ASR: begin
          q_next    = {q[WIDTH-1], q[WIDTH-1:1]};
          sout_next = q[0];
        end
        default: begin
          // Only reachable with an unknown mode; propagate X so it is visible.
          q_next = {WIDTH{1'bx}};
        end
      endcase
    end
  end

endmodule : univ_register_next
`default_nettype wire

// File: rtl/univ_register.sv
`default_nettype none
// ============================================================================
// Module   : univ_register
// Purpose  : Parametrised general-purpose datapath register with parallel
//            load, shift/rotate/arithmetic shift, increment/decrement,
//            serial output, carry/borrow and terminal-count/zero flags.
//            WIDTH must be at least 2.
// Revision : 1.0 - initial release
// ============================================================================
module univ_register
  import univ_register_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              load,
  input  logic [WIDTH-1:0]  d,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic              sin,
  output logic [WIDTH-1:0]  q,
  output logic              sout,
  output logic              carry,
  output logic              tc,
  output logic              zero
);

  logic [WIDTH-1:0] r_q;
  logic             r_sout;
  logic             r_carry;

  logic [WIDTH-1:0] w_q_next;
  logic             w_sout_next;
  logic             w_carry_next;
  logic             w_all_ones;
  logic             w_is_zero;

  univ_register_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .q          (r_q),
    .sout       (r_sout),
    .carry      (r_carry),
    .load       (load),
    .d          (d),
    .en         (en),
    .mode       (mode),
    .sin        (sin),
    .q_next     (w_q_next),
    .sout_next  (w_sout_next),
    .carry_next (w_carry_next)
  );

  // State flops; clear acts immediately and discards any in-flight update.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_q     <= RESET_VALUE;
      r_sout  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_q     <= w_q_next;
      r_sout  <= w_sout_next;
      r_carry <= w_carry_next;
    end
  end

  assign w_all_ones = &r_q;
  assign w_is_zero  = (r_q == '0);

  // tc predicts the wrap the next edge will perform.
  assign tc    = en & ~load & (((mode == MODE_INC) & w_all_ones) |
                               ((mode == MODE_DEC) & w_is_zero));
  assign zero  = w_is_zero;
  assign q     = r_q;
  assign sout  = r_sout;
  assign carry = r_carry;

  // An unknown mode while an operation is requested is a protocol violation.
  always @(posedge clk) begin
    if (!clear && en && !load) begin
      assert (!$isunknown(mode))
        else $error("univ_register: unknown mode while en=1 and load=0");
    end
  end

endmodule : univ_register
`default_nettype wire
